// File: rtl/dac_amp_scaler.sv
// dac_amp_scaler: pipelined amplitude stage between the DDS sine source and
// the 10-bit DAC. Each signed DDS sample is scaled by a per-frequency
// compensation coefficient (unsigned Q10) and by the amplitude code
// (10..20 = 1.0..2.0 Vpp). The result is converted to offset-binary and
// saturated. Coefficient and gain changes are deferred to a zero-crossing
// of the sample stream so that the DAC waveform never steps.
//
// Ports:
//   clk          DAC sample clock
//   rst_n        synchronous reset, active-low
//   sample_in    signed DDS sample, two's complement (10b)
//   sample_valid sample_in valid this cycle
//   gain_code    target amplitude code, quasi-static (5b)
//   comp_coef    target compensation coefficient, unsigned Q10 (11b)
//   da_data      offset-binary DAC code (10b)
//   da_valid     da_data updated this cycle
//   sat_flag     sample on da_data was clipped
//   upd_pending  target differs from active, waiting for a zero-crossing
//
// Latency is fixed at 4 cycles from the accepting edge to da_valid.

module dac_amp_scaler #(
    parameter int TIMEOUT_SAMPLES = 4096,
    parameter int GAIN_MIN        = 10,
    parameter int GAIN_MAX        = 20,
    parameter int GAIN_RST        = 10,
    parameter int COEF_RST        = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [9:0] sample_in,
    input  logic              sample_valid,
    input  logic        [4:0] gain_code,
    input  logic       [10:0] comp_coef,
    output logic        [9:0] da_data,
    output logic              da_valid,
    output logic              sat_flag,
    output logic              upd_pending
);

    localparam int CW = (TIMEOUT_SAMPLES > 2) ? $clog2(TIMEOUT_SAMPLES) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_SAMPLES - 1);

    // ------------------------------------------------------------------
    // Target evaluation and update FSM
    // ------------------------------------------------------------------
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          prev_neg;
    logic [4:0]    act_gain;
    logic [10:0]   act_coef;

    logic [4:0]    tgt_gain;
    logic          sign_neg;
    logic          crossing;
    logic          differs;
    logic          timed_out;
    logic          load;
    logic [4:0]    use_gain;
    logic [10:0]   use_coef;

    // Out-of-range amplitude codes are pulled back into the legal band.
    always_comb begin
        tgt_gain = gain_code;
        if (gain_code < 5'(GAIN_MIN)) begin
            tgt_gain = 5'(GAIN_MIN);
        end else if (gain_code > 5'(GAIN_MAX)) begin
            tgt_gain = 5'(GAIN_MAX);
        end
    end

    // Zero is treated as a positive sample for crossing detection.
    assign sign_neg  = sample_in[9];
    assign crossing  = (sign_neg != prev_neg);
    assign differs   = (tgt_gain != act_gain) || (comp_coef != act_coef);
    assign timed_out = (cnt == CNT_LAST);

    // A crossing and a timeout on the same sample collapse into one load.
    always_comb begin
        load = 1'b0;
        if (sample_valid && (state == ST_PEND) && differs) begin
            load = crossing || timed_out;
        end
    end

    // The loading sample is itself scaled with the new values.
    assign use_gain = load ? tgt_gain  : act_gain;
    assign use_coef = load ? comp_coef : act_coef;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            prev_neg <= 1'b0;
            act_gain <= 5'(GAIN_RST);
            act_coef <= 11'(COEF_RST);
        end else if (sample_valid) begin
            prev_neg <= sign_neg;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (differs) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!differs) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (load) begin
                        act_gain <= tgt_gain;
                        act_coef <= comp_coef;
                        state    <= ST_IDLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign upd_pending = (state == ST_PEND);

    // ------------------------------------------------------------------
    // Stage 1: capture sample with the coefficient/gain it must use
    // ------------------------------------------------------------------
    logic              v1;
    logic signed [9:0] s1_s;
    logic       [10:0] s1_c;
    logic        [4:0] s1_g;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_s <= '0;
            s1_c <= '0;
            s1_g <= '0;
        end else begin
            v1 <= sample_valid;
            if (sample_valid) begin
                s1_s <= sample_in;
                s1_c <= use_coef;
                s1_g <= use_gain;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: exact product s*c*g (|p| < 2^25, fits 27b signed)
    // ------------------------------------------------------------------
    logic signed [26:0] s_ext;
    logic signed [26:0] c_ext;
    logic signed [26:0] g_ext;
    logic signed [26:0] p_next;
    logic               v2;
    logic signed [26:0] s2_p;

    assign s_ext  = {{17{s1_s[9]}}, s1_s};
    assign c_ext  = {16'b0, s1_c};
    assign g_ext  = {22'b0, s1_g};
    assign p_next = s_ext * c_ext * g_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2_p <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2_p <= p_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: floor shift by 10, then divide by 10 toward zero
    // ------------------------------------------------------------------
    logic signed [26:0] q;
    logic signed [26:0] r_next;
    logic               v3;
    logic signed [26:0] s3_r;

    assign q      = s2_p >>> 10;
    assign r_next = q / 27'sd10;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            s3_r <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                s3_r <= r_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: offset-binary conversion
    // ------------------------------------------------------------------
    logic               v4;
    logic signed [26:0] s4_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v4   <= 1'b0;
            s4_y <= '0;
        end else begin
            v4 <= v3;
            if (v3) begin
                s4_y <= s3_r + 27'sd512;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output: saturate to the DAC range; hold data while idle
    // ------------------------------------------------------------------
    logic [9:0] sat_data;
    logic       sat_hit;

    always_comb begin
        sat_data = s4_y[9:0];
        sat_hit  = 1'b0;
        if (s4_y < 27'sd0) begin
            sat_data = 10'd0;
            sat_hit  = 1'b1;
        end else if (s4_y > 27'sd1023) begin
            sat_data = 10'd1023;
            sat_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            da_valid <= 1'b0;
            da_data  <= 10'd512;
            sat_flag <= 1'b0;
        end else begin
            da_valid <= v4;
            if (v4) begin
                da_data  <= sat_data;
                sat_flag <= sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_dac_amp_scaler.sv
// tb_dac_amp_scaler: directed testbench for dac_amp_scaler.
// Applies hand-computed vectors and prints one summary line.

module tb_dac_amp_scaler;

    logic              clk;
    logic              rst_n;
    logic signed [9:0] sample_in;
    logic              sample_valid;
    logic        [4:0] gain_code;
    logic       [10:0] comp_coef;
    logic        [9:0] da_data;
    logic              da_valid;
    logic              sat_flag;
    logic              upd_pending;

    int n_vec = 0;
    int n_err = 0;

    dac_amp_scaler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .gain_code    (gain_code),
        .comp_coef    (comp_coef),
        .da_data      (da_data),
        .da_valid     (da_valid),
        .sat_flag     (sat_flag),
        .upd_pending  (upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_y(input int s, input int c, input int g);
        int p;
        int q;
        int r;
        p = s * c * g;
        q = p >>> 10;
        r = q / 10;
        return r + 512;
    endfunction

    // One isolated sample, checked at exactly 4 cycles of latency.
    task automatic send_chk(input string tag, input int s, input int exp_d,
                            input int exp_sat, input int exp_pend);
        sample_in    = 10'(s);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check({tag, "_pend"}, int'(upd_pending), exp_pend);
        repeat (3) tick();
        check({tag, "_early"}, int'(da_valid), 0);
        tick();
        check({tag, "_valid"}, int'(da_valid), 1);
        check({tag, "_data"}, int'(da_data), exp_d);
        check({tag, "_sat"}, int'(sat_flag), exp_sat);
    endtask

    int sine_s[8]    = '{100, 200, 300, 200, 100, 0, -100, -200};
    int sine_y[8]    = '{612, 712, 812, 712, 612, 512, 362, 212};
    int sine_pend[8] = '{0, 0, 1, 1, 1, 1, 0, 0};

    localparam int NSW = 48;
    int sw_s[NSW];

    initial begin
        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        gain_code    = 5'd10;
        comp_coef    = 11'd1024;
        repeat (3) tick();
        check("rst_data", int'(da_data), 512);
        check("rst_valid", int'(da_valid), 0);
        check("rst_sat", int'(sat_flag), 0);
        check("rst_pend", int'(upd_pending), 0);
        rst_n = 1'b1;
        tick();

        // Basic scaling at unity coefficient, gain 10
        send_chk("t1", 100, 612, 0, 0);

        // Gain 20 loaded on a crossing; saturation both ways
        gain_code = 5'd20;
        send_chk("t2a", 1, 513, 0, 1);
        send_chk("t2b", -512, 0, 1, 0);
        send_chk("t2c", 511, 1023, 1, 0);

        // Truncation toward zero and floor shift
        gain_code = 5'd15;
        send_chk("t3a", 0, 512, 0, 1);
        send_chk("t3b", -7, 502, 0, 0);
        gain_code = 5'd10;
        comp_coef = 11'd1000;
        send_chk("t3c", 2, 515, 0, 1);
        send_chk("t3d", -1, 511, 0, 0);

        // Timeout: constant positive input, coefficient change
        comp_coef = 11'd1024;
        for (int t = 0; t <= 4100; t++) begin
            sample_in    = 10'sd50;
            sample_valid = (t <= 4096);
            tick();
            if (t == 0)    check("to_pend0", int'(upd_pending), 1);
            if (t == 4095) check("to_pend4095", int'(upd_pending), 1);
            if (t == 4096) check("to_pend4096", int'(upd_pending), 0);
            if (t == 4099) check("to_old", int'(da_data), 560);
            if (t == 4100) begin
                check("to_new_v", int'(da_valid), 1);
                check("to_new", int'(da_data), 562);
            end
        end
        sample_valid = 1'b0;
        tick();

        // Sine stream, gain change in the positive half-cycle
        for (int t = 0; t < 12; t++) begin
            if (t == 2) gain_code = 5'd15;
            sample_valid = (t < 8);
            if (t < 8) sample_in = 10'(sine_s[t]);
            tick();
            if (t < 8) check($sformatf("sine_pend%0d", t),
                             int'(upd_pending), sine_pend[t]);
            if (t >= 4) begin
                check($sformatf("sine_v%0d", t - 4), int'(da_valid), 1);
                check($sformatf("sine_y%0d", t - 4), int'(da_data),
                      sine_y[t - 4]);
            end
        end
        sample_valid = 1'b0;
        tick();

        // Random sweep at c=1024, g=15 against the reference formula
        for (int i = 0; i < NSW; i++) begin
            sw_s[i] = int'($urandom_range(0, 1023)) - 512;
        end
        sw_s[0] = -512;
        sw_s[1] = 511;
        for (int t = 0; t < NSW + 4; t++) begin
            sample_valid = (t < NSW);
            if (t < NSW) sample_in = 10'(sw_s[t]);
            tick();
            if (t >= 4) begin
                int y;
                int ey;
                int es;
                y  = ref_y(sw_s[t - 4], 1024, 15);
                ey = (y < 0) ? 0 : ((y > 1023) ? 1023 : y);
                es = (y < 0 || y > 1023) ? 1 : 0;
                check($sformatf("sw_y%0d", t - 4), int'(da_data), ey);
                check($sformatf("sw_s%0d", t - 4), int'(sat_flag), es);
            end
        end
        sample_valid = 1'b0;
        tick();

        // Gain clamp (25 -> 20) and zero coefficient
        send_chk("cl0", 0, 512, 0, 0);
        gain_code = 5'd25;
        send_chk("cl1", 1, 513, 0, 1);
        send_chk("cl2", -100, 312, 0, 0);
        comp_coef = 11'd0;
        send_chk("cz1", 3, 518, 0, 1);
        send_chk("cz2", -400, 512, 0, 0);

        // Reset with three samples in flight
        gain_code = 5'd10;
        comp_coef = 11'd1024;
        for (int t = 0; t < 3; t++) begin
            sample_in    = 10'sd200;
            sample_valid = 1'b1;
            tick();
        end
        check("mr_pend_pre", int'(upd_pending), 1);
        sample_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_data", int'(da_data), 512);
        check("mr_pend", int'(upd_pending), 0);
        for (int t = 0; t < 6; t++) begin
            check($sformatf("mr_novalid%0d", t), int'(da_valid), 0);
            tick();
        end
        send_chk("mr_after", 100, 612, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
